// File: rtl/push_debouncer.sv
// Push-button debouncer: accepts a level change only after DEBOUNCE_CYCLES consecutive
// identical samples and emits registered one-cycle press/release strobes.
module push_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic synchronous_push,
  output logic push_level,
  output logic push_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StPressed,
    StRelChk
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             push_pulse_d;
  logic             release_pulse_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    level_d         = push_level;
    push_pulse_d    = 1'b0;
    release_pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        level_d = 1'b0;
        if (synchronous_push) begin
          state_d = StPressChk;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end

      StPressChk: begin
        level_d = 1'b0;
        if (!synchronous_push) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d      = StPressed;
          cnt_d        = '0;
          level_d      = 1'b1;
          push_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StPressed: begin
        level_d = 1'b1;
        if (!synchronous_push) begin
          state_d = StRelChk;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end

      StRelChk: begin
        level_d = 1'b1;
        if (synchronous_push) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d         = StIdle;
          cnt_d           = '0;
          level_d         = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Reset wins over any acceptance due on the same edge, so no strobe escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      push_level    <= 1'b0;
      push_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      push_level    <= level_d;
      push_pulse    <= push_pulse_d;
      release_pulse <= release_pulse_d;
    end
  end

endmodule

// File: tb/tb_push_debouncer.sv
// Directed bench for push_debouncer: a run-length reference model pushes expected outputs to a
// scoreboard queue on each driven sample; they are popped and compared after the clock edge.
module tb_push_debouncer;

  localparam int unsigned D = 4;
  localparam int unsigned W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic synchronous_push = 1'b0;
  logic push_level, push_pulse, release_pulse;

  push_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .synchronous_push(synchronous_push),
    .push_level      (push_level),
    .push_pulse      (push_pulse),
    .release_pulse   (release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic lvl;
    logic pp;
    logic rp;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model: level plus length of the current run of samples that disagree with it.
  logic m_lvl = 1'b0;
  int   m_run = 0;

  int  n_push = 0;
  int  n_rel  = 0;
  logic last_push = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic x);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r;
    synchronous_push = x;
    e = '0;
    if (r) begin
      m_lvl = 1'b0;
      m_run = 0;
    end else if (x != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = x;
        m_run = 0;
        if (x) e.pp = 1'b1;
        else e.rp = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    e.lvl = m_lvl;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard: observed empty queue required entry");
    end else begin
      got = sb.pop_front();
      check("push_level", push_level, got.lvl);
      check("push_pulse", push_pulse, got.pp);
      check("release_pulse", release_pulse, got.rp);
      check("pulse_overlap", push_pulse & release_pulse, 1'b0);
    end
    if (r) last_push = 1'b0;
    if (push_pulse) begin
      n_push++;
      check("alternate_push", last_push, 1'b0);
      last_push = 1'b1;
    end
    if (release_pulse) begin
      n_rel++;
      check("alternate_release", last_push, 1'b1);
      last_push = 1'b0;
    end
  endtask

  task automatic run(input logic x, input int n);
    for (int i = 0; i < n; i++) step(1'b0, x);
  endtask

  int p0, r0;

  initial begin
    // Reset for two cycles.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset_level", push_level, 1'b0);

    // Clean press.
    p0 = n_push; r0 = n_rel;
    run(1'b1, 3);
    check("press_not_yet", push_level, 1'b0);
    run(1'b1, 1);
    check("press_accept_pulse", push_pulse, 1'b1);
    run(1'b1, 3);
    check("press_level_held", push_level, 1'b1);
    check_int("clean_press_pushes", n_push - p0, 1);
    check_int("clean_press_releases", n_rel - r0, 0);

    // Clean release.
    p0 = n_push; r0 = n_rel;
    run(1'b0, 4);
    check("release_accept_pulse", release_pulse, 1'b1);
    run(1'b0, 3);
    check("release_level_low", push_level, 1'b0);
    check_int("clean_release_count", n_rel - r0, 1);

    // Bounced press: 1,1,1,0,1,1,1,1.
    p0 = n_push;
    run(1'b1, 3);
    run(1'b0, 1);
    check_int("bounce_no_early_pulse", n_push - p0, 0);
    run(1'b1, 3);
    check("bounce_still_low", push_level, 1'b0);
    run(1'b1, 1);
    check("bounce_press_pulse", push_pulse, 1'b1);
    run(1'b1, 2);
    check_int("bounce_press_count", n_push - p0, 1);

    // Release bounce: 0,0,1,0,0,0,0.
    r0 = n_rel;
    run(1'b0, 2);
    run(1'b1, 1);
    run(1'b0, 3);
    check("relbounce_level_held", push_level, 1'b1);
    run(1'b0, 1);
    check("relbounce_pulse", release_pulse, 1'b1);
    run(1'b0, 2);
    check_int("relbounce_count", n_rel - r0, 1);

    // Reset mid-qualification with input still high, then re-qualify.
    p0 = n_push;
    run(1'b1, 3);
    step(1'b1, 1'b1);
    check("midreset_level", push_level, 1'b0);
    check_int("midreset_no_pulse", n_push - p0, 0);
    run(1'b1, 3);
    check("midreset_not_yet", push_level, 1'b0);
    run(1'b1, 1);
    check("midreset_press_pulse", push_pulse, 1'b1);
    run(1'b1, 2);

    // Reset while pressed: level drops without a release strobe.
    r0 = n_rel;
    step(1'b1, 1'b1);
    check("pressed_reset_level", push_level, 1'b0);
    check("pressed_reset_no_rel", release_pulse, 1'b0);
    check_int("pressed_reset_rel_count", n_rel - r0, 0);
    // Button held through reset: accepted again from IDLE.
    p0 = n_push;
    run(1'b1, 6);
    check_int("held_through_reset_press", n_push - p0, 1);
    run(1'b0, 6);

    // Rapid repeat.
    p0 = n_push; r0 = n_rel;
    for (int k = 0; k < 5; k++) begin
      run(1'b1, 6);
      run(1'b0, 6);
    end
    check_int("rapid_pushes", n_push - p0, 5);
    check_int("rapid_releases", n_rel - r0, 5);
    check_int("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
